debug_tx_arbiter: RTL and testbench

- Shares the single debug UART transmitter (AXI-Stream byte sink with `tready`) between NUM_SRC debug message producers, e.g. the flight loop, ESC/DShot monitor and SPI bridge.
- Arbitration is round-robin and packet-locked: a granted source keeps the UART until it sends a byte with `tlast`.
- An optional ASCII source tag is sent before each packet.
- A stall timeout stops a hung source from blocking the port.
- Sits between the producers and the UART TX wrapper's AXI-Stream input.

---
 rtl/debug_tx_if.sv | 23 ++
 rtl/debug_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_debug_tx_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_tx_if.sv
// AXI-Stream bundle between the debug message producers, the arbiter and the UART TX input.
// slave is the arbiter's view; master is the view of whatever drives the sources and the sink ready.
interface debug_tx_if #(
  parameter int NUM_SRC = 4
) ();
  logic [NUM_SRC*8-1:0] s_tdata;
  logic [NUM_SRC-1:0]   s_tvalid;
  logic [NUM_SRC-1:0]   s_tlast;
  logic [NUM_SRC-1:0]   s_tready;
  logic [7:0]           m_tdata;
  logic                 m_tvalid;
  logic                 m_tready;

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/debug_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one debug UART TX byte stream between NUM_SRC
// producers, with an optional ASCII source tag per packet and a mid-packet stall timeout.
module debug_tx_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter bit TAG_EN         = 1'b1,
  parameter int TIMEOUT_CYCLES = 72000
) (
  input  logic               clk,
  input  logic               rst_n,
  debug_tx_if.slave          bus,
  output logic [NUM_SRC-1:0] grant,
  output logic               busy,
  output logic               timeout_pulse
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, TAG, STREAM} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  int                 cand;
  logic               src_vld;
  logic               hs;
  logic               tout;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    grant_d   = grant_q;
    stall_d   = stall_q;
    timeout_d = 1'b0;
    found     = 1'b0;
    pick      = '0;
    cand      = 0;
    src_vld   = 1'b0;
    hs        = 1'b0;
    tout      = 1'b0;
    bus.m_tdata  = '0;
    bus.m_tvalid = 1'b0;
    bus.s_tready = '0;

    case (state_q)
      IDLE: begin
        // Search starts just after the previous owner so every requester gets a turn.
        for (int k = 1; k <= NUM_SRC; k++) begin
          cand = (int'(last_q) + k) % NUM_SRC;
          if (!found && bus.s_tvalid[cand]) begin
            found = 1'b1;
            pick  = IDX_W'(cand);
          end
        end
        if (found) begin
          idx_d   = pick;
          grant_d = NUM_SRC'(1) << pick;
          state_d = TAG_EN ? TAG : STREAM;
        end
      end

      TAG: begin
        bus.m_tvalid = 1'b1;
        bus.m_tdata  = 8'h30 + 8'(idx_q);
        if (bus.m_tready) state_d = STREAM;
      end

      STREAM: begin
        src_vld = bus.s_tvalid[idx_q];
        hs      = src_vld && bus.m_tready;
        // Only an idle source can time out, so a byte offered on the expiry cycle still wins.
        tout    = (TIMEOUT_CYCLES > 0) && !src_vld && (stall_q >= TO_VAL);
        bus.m_tdata  = bus.s_tdata[int'(idx_q)*8 +: 8];
        bus.m_tvalid = src_vld;
        bus.s_tready[idx_q] = bus.m_tready;
        if (hs) begin
          stall_d = '0;
        end else if (!src_vld && stall_q != CNT_MAX) begin
          stall_d = stall_q + 1'b1;
        end
        if ((hs && bus.s_tlast[idx_q]) || tout) begin
          state_d   = IDLE;
          last_d    = idx_q;
          grant_d   = '0;
          timeout_d = tout;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d != STREAM) stall_d = '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_SRC - 1);
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = busy_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_debug_tx_arbiter.sv
// Scoreboard bench for debug_tx_arbiter: tagged/timeout instance (dut_a) and untagged,
// no-timeout instance (dut_b) sharing one clock and reset.
module tb_debug_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_tx_if #(.NUM_SRC(N)) ifa ();
  debug_tx_if #(.NUM_SRC(N)) ifb ();

  logic [N-1:0] grant_a, grant_b;
  logic busy_a, busy_b, to_a, to_b;

  debug_tx_arbiter #(.NUM_SRC(N), .TAG_EN(1'b1), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .grant(grant_a), .busy(busy_a), .timeout_pulse(to_a));

  debug_tx_arbiter #(.NUM_SRC(N), .TAG_EN(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .grant(grant_b), .busy(busy_b), .timeout_pulse(to_b));

  typedef struct {
    logic [7:0] data;
    int         src;
    bit         tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       expb_q[$];
  logic [8:0] src_q[N][$];
  bit         hs_prev[N];
  bit         rdy_toggle;
  int         vectors;
  int         miscompares;

  task automatic push_pkt(input int s, input string str, input bit with_last);
    exp_t e;
    logic [7:0] ch;
    logic lst;
    e.data = 8'h30 + 8'(s);
    e.src  = s;
    e.tag  = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < str.len(); i++) begin
      ch  = str[i];
      lst = with_last && (i == str.len() - 1);
      src_q[s].push_back({lst, ch});
      e.data = ch;
      e.tag  = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // One clock of the dut_a source model: retire accepted bytes, present the next ones.
  task automatic cycle();
    logic [N*8-1:0] td;
    logic [N-1:0] tv, tl;
    logic [8:0] junk;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs_prev[i] && src_q[i].size() > 0) junk = src_q[i].pop_front();
    td = '0; tv = '0; tl = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        tv[i] = 1'b1;
        tl[i] = src_q[i][0][8];
        td[i*8 +: 8] = src_q[i][0][7:0];
      end
    end
    ifa.s_tdata  = td;
    ifa.s_tvalid = tv;
    ifa.s_tlast  = tl;
    ifa.m_tready = rdy_toggle ? ~ifa.m_tready : 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) hs_prev[i] = ifa.s_tvalid[i] && ifa.s_tready[i];
  endtask

  task automatic clear_a();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      hs_prev[i] = 1'b0;
    end
    ifa.s_tdata = '0; ifa.s_tvalid = '0; ifa.s_tlast = '0; ifa.m_tready = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_a();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.s_tvalid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (grant_a !== 4'b0000 || busy_a !== 1'b0 || to_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs grant=%b busy=%b timeout=%b required 0000/0/0", grant_a, busy_a, to_a);
    end
    vectors++;
    if (ifa.m_tvalid !== 1'b0 || ifa.m_tdata !== 8'h00 || ifa.s_tready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_bus m_tvalid=%b m_tdata=%h s_tready=%b required 0/00/0000",
               ifa.m_tvalid, ifa.m_tdata, ifa.s_tready);
    end
    vectors++;
    if (grant_b !== 4'b0000 || busy_b !== 1'b0 || ifb.m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b grant=%b busy=%b m_tvalid=%b required 0000/0/0", grant_b, busy_b, ifb.m_tvalid);
    end
    clear_a();
    rst_n = 1'b1;
  endtask

  task automatic test_tag_packet();
    exp_t e;
    logic [N-1:0] wg, wr;
    push_pkt(2, "AB", 1'b1);
    for (int n = 0; n < 30 && exp_q.size() > 0; n++) begin
      cycle();
      if (ifa.m_tvalid && ifa.m_tready) begin
        e = exp_q.pop_front();
        wg = N'(1) << e.src;
        wr = e.tag ? '0 : wg;
        vectors++;
        if (ifa.m_tdata !== e.data || grant_a !== wg || ifa.s_tready !== wr || busy_a !== 1'b1) begin
          miscompares++;
          $display("FAIL t1_byte data=%h grant=%b rdy=%b busy=%b required data=%h grant=%b rdy=%b busy=1",
                   ifa.m_tdata, grant_a, ifa.s_tready, busy_a, e.data, wg, wr);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL t1_timeout bytes outstanding=%0d required 0", exp_q.size());
    end
    cycle();
    vectors++;
    if (grant_a !== 4'b0000 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_release grant=%b busy=%b required 0000/0", grant_a, busy_a);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [N-1:0] wg, wr;
    apply_reset();
    push_pkt(0, "a1", 1'b1); push_pkt(1, "b1", 1'b1); push_pkt(3, "d1", 1'b1);
    push_pkt(0, "a2", 1'b1); push_pkt(1, "b2", 1'b1); push_pkt(3, "d2", 1'b1);
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) begin
      cycle();
      if (ifa.m_tvalid && ifa.m_tready) begin
        e = exp_q.pop_front();
        wg = N'(1) << e.src;
        wr = e.tag ? '0 : wg;
        vectors++;
        if (ifa.m_tdata !== e.data || grant_a !== wg || ifa.s_tready !== wr) begin
          miscompares++;
          $display("FAIL t2_order data=%h grant=%b rdy=%b required data=%h grant=%b rdy=%b",
                   ifa.m_tdata, grant_a, ifa.s_tready, e.data, wg, wr);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL t2_timeout bytes outstanding=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [N-1:0] wg, wr;
    logic [7:0] held;
    bit hold, saw_to;
    hold = 1'b0; saw_to = 1'b0; held = '0;
    rdy_toggle = 1'b1;
    push_pkt(1, "HELLO", 1'b1);
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
      cycle();
      if (to_a) saw_to = 1'b1;
      if (hold) begin
        vectors++;
        if (ifa.m_tvalid !== 1'b1 || ifa.m_tdata !== held) begin
          miscompares++;
          $display("FAIL t3_stable m_tvalid=%b m_tdata=%h required 1/%h", ifa.m_tvalid, ifa.m_tdata, held);
        end
      end
      hold = ifa.m_tvalid && !ifa.m_tready;
      held = ifa.m_tdata;
      if (ifa.m_tvalid && ifa.m_tready) begin
        e = exp_q.pop_front();
        wg = N'(1) << e.src;
        wr = e.tag ? '0 : wg;
        vectors++;
        if (ifa.m_tdata !== e.data || grant_a !== wg || ifa.s_tready !== wr) begin
          miscompares++;
          $display("FAIL t3_byte data=%h grant=%b rdy=%b required data=%h grant=%b rdy=%b",
                   ifa.m_tdata, grant_a, ifa.s_tready, e.data, wg, wr);
        end
      end
    end
    rdy_toggle = 1'b0;
    vectors++;
    if (exp_q.size() != 0 || saw_to) begin
      miscompares++;
      $display("FAIL t3_done outstanding=%0d timeout_seen=%b required 0/0", exp_q.size(), saw_to);
    end
    cycle();
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [N-1:0] wg, wr;
    int c_hs;
    c_hs = -100;
    push_pkt(0, "X", 1'b0);
    push_pkt(1, "ok", 1'b1);
    for (int n = 0; n < 50; n++) begin
      cycle();
      if (ifa.m_tvalid && ifa.m_tready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL t4_extra data=%h required no byte", ifa.m_tdata);
        end else begin
          e = exp_q.pop_front();
          wg = N'(1) << e.src;
          wr = e.tag ? '0 : wg;
          if (!e.tag && e.src == 0) c_hs = n;
          if (ifa.m_tdata !== e.data || grant_a !== wg || ifa.s_tready !== wr) begin
            miscompares++;
            $display("FAIL t4_byte data=%h grant=%b rdy=%b required data=%h grant=%b rdy=%b",
                     ifa.m_tdata, grant_a, ifa.s_tready, e.data, wg, wr);
          end
        end
      end
      if (c_hs >= 0 && n > c_hs) begin
        vectors++;
        if (to_a !== (n == c_hs + 18)) begin
          miscompares++;
          $display("FAIL t4_pulse cycle=%0d timeout_pulse=%b required %b", n - c_hs, to_a, n == c_hs + 18);
        end
        if (n == c_hs + 17) begin
          vectors++;
          if (ifa.m_tvalid !== 1'b0 || grant_a !== 4'b0001) begin
            miscompares++;
            $display("FAIL t4_expiry m_tvalid=%b grant=%b required 0/0001", ifa.m_tvalid, grant_a);
          end
        end
        if (n == c_hs + 18) begin
          vectors++;
          if (grant_a !== 4'b0000) begin
            miscompares++;
            $display("FAIL t4_revoke grant=%b required 0000", grant_a);
          end
        end
        if (n == c_hs + 19) begin
          vectors++;
          if (grant_a !== 4'b0010) begin
            miscompares++;
            $display("FAIL t4_regrant grant=%b required 0010", grant_a);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0 || c_hs < 0) begin
      miscompares++;
      $display("FAIL t4_done outstanding=%0d first_byte_seen=%b required 0/1", exp_q.size(), c_hs >= 0);
    end
  endtask

  task automatic test_reset_mid_packet();
    exp_t e;
    logic [N-1:0] wg, wr;
    bit hit;
    hit = 1'b0;
    push_pkt(2, "WXYZ", 1'b1);
    for (int n = 0; n < 30 && !hit; n++) begin
      cycle();
      if (ifa.m_tvalid && ifa.m_tready) begin
        e = exp_q.pop_front();
        wg = N'(1) << e.src;
        wr = e.tag ? '0 : wg;
        vectors++;
        if (ifa.m_tdata !== e.data || grant_a !== wg || ifa.s_tready !== wr) begin
          miscompares++;
          $display("FAIL t5_byte data=%h grant=%b rdy=%b required data=%h grant=%b rdy=%b",
                   ifa.m_tdata, grant_a, ifa.s_tready, e.data, wg, wr);
        end
        if (!e.tag && e.data == 8'h59) hit = 1'b1;
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL t5_reach third byte seen=0 required 1");
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (ifa.m_tvalid !== 1'b0 || ifa.s_tready !== 4'b0000 || grant_a !== 4'b0000 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_async m_tvalid=%b s_tready=%b grant=%b busy=%b required 0/0000/0000/0",
               ifa.m_tvalid, ifa.s_tready, grant_a, busy_a);
    end
    clear_a();
    cycle();
    rst_n = 1'b1;
    push_pkt(0, "s", 1'b1);
    push_pkt(1, "r", 1'b1);
    for (int n = 0; n < 30 && exp_q.size() > 0; n++) begin
      cycle();
      if (ifa.m_tvalid && ifa.m_tready) begin
        e = exp_q.pop_front();
        wg = N'(1) << e.src;
        vectors++;
        if (ifa.m_tdata !== e.data || grant_a !== wg) begin
          miscompares++;
          $display("FAIL t5_after data=%h grant=%b required data=%h grant=%b", ifa.m_tdata, grant_a, e.data, wg);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL t5_timeout bytes outstanding=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_no_tag_no_timeout();
    exp_t e;
    bit done, bad;
    e.src = 3; e.tag = 1'b0;
    e.data = 8'h50; expb_q.push_back(e);
    e.data = 8'h51; expb_q.push_back(e);
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      ifb.s_tvalid = 4'b1000;
      ifb.s_tdata  = {expb_q[0].data, 24'h0};
      ifb.s_tlast  = (b == 1) ? 4'b1000 : 4'b0000;
      done = 1'b0;
      for (int n = 0; n < 10 && !done; n++) begin
        @(negedge clk);
        if (ifb.m_tvalid && ifb.m_tready) begin
          done = 1'b1;
          e = expb_q.pop_front();
          vectors++;
          if (ifb.m_tdata !== e.data || grant_b !== 4'b1000 || ifb.s_tready !== 4'b1000) begin
            miscompares++;
            $display("FAIL t6_byte data=%h grant=%b rdy=%b required data=%h grant=1000 rdy=1000",
                     ifb.m_tdata, grant_b, ifb.s_tready, e.data);
          end
        end
      end
      vectors++;
      if (!done) begin
        miscompares++;
        $display("FAIL t6_wait byte %0d handshake=0 required 1", b);
      end
      @(posedge clk); #1;
      ifb.s_tvalid = '0;
      ifb.s_tlast  = '0;
      if (b == 0) begin
        bad = 1'b0;
        for (int n = 0; n < 10000; n++) begin
          @(negedge clk);
          if (grant_b !== 4'b1000 || to_b !== 1'b0 || ifb.m_tvalid !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
          miscompares++;
          $display("FAIL t6_stall grant=%b timeout=%b m_tvalid=%b required 1000/0/0 throughout",
                   grant_b, to_b, ifb.m_tvalid);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (grant_b !== 4'b0000 || busy_b !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_release grant=%b busy=%b required 0000/0", grant_b, busy_b);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rdy_toggle = 1'b0;
    clear_a();
    ifb.s_tdata = '0; ifb.s_tvalid = '0; ifb.s_tlast = '0; ifb.m_tready = 1'b1;
    test_reset();
    test_tag_packet();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_packet();
    test_no_tag_no_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
